mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port data/instruction RAM between two requesters: the instruction-fetch stage (IF) and the load/store stage (DM). It drives the RAM port, sequences read latency wait-states, and returns read data with a valid pulse. Fixed priority goes to DM. A starvation counter guarantees fetch progress. It sits between the pipeline front/back ends and the unified memory in the pipelined processor.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 2, RAM read latency in cycles (1..7); read data is valid LAT cycles after the address is driven
STARVE_MAX, 4, maximum number of consecutive DM grants while if_req is pending (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetch read data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  one-cycle pulse, dm_rdata valid (reads only)
dm_rdata  out  DW  data read data
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data
busy  out  1  read outstanding; no new grant possible

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, outstanding owner cleared. All gnt, rvalid, mem_we and busy are 0; mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
- States: IDLE (arbitration allowed) and WAIT (read outstanding, count=LAT-1..0).
- Arbitration is combinational in IDLE, or in the final WAIT cycle. Exactly one gnt is high per cycle at most.
  - DM wins when starve_cnt<STARVE_MAX or if_req=0.
  - IF wins when dm_req=0, or when starve_cnt==STARVE_MAX and if_req=1.
- On a grant cycle, mem_addr/mem_wdata come from the winner. mem_we=dm_we only for a DM grant, and 0 otherwise. When no grant, mem_we=0 and mem_addr/mem_wdata=0.
- Write grant: completes in the grant cycle. There is no rvalid. The FSM stays in IDLE, so the next grant is possible in the following cycle.
- Read grant at cycle T: enter WAIT and record the owner (IF/DM).
  - At T+LAT, the owner's rvalid=1 and the owner's rdata=mem_rdata (registered copy held until the next rvalid for that owner).
  - busy=1 during cycles T+1..T+LAT-1.
  - A new grant is permitted in cycle T+LAT (same cycle as rvalid). If none is made, return to IDLE.
  - LAT=1: no busy cycles; back-to-back reads are possible every cycle.
- starve_cnt:
  - +1 on each DM grant while if_req=1, saturating at STARVE_MAX.
  - Cleared on any IF grant, or in any cycle with if_req=0.
- Requester rules: req, addr, we and wdata must be stable from assertion until gnt. Dropping req before gnt is a protocol violation and the result is unspecified. A requester may re-assert req in its own rvalid cycle.
- Reset mid-read: the outstanding read is discarded, no rvalid is issued, and the FSM returns to IDLE. Arbitration resumes on the first clock after rst=1.
- rdata registers update only on the owning rvalid cycle. The other requester's rdata is unchanged.

Test Plan:
1. Reset: hold rst=0 with if_req=dm_req=1 -> all gnt/rvalid/mem_we/busy=0, rdata=0. Release rst -> DM granted first cycle.
2. Single fetch, LAT=2: if_req with if_addr=0x40 at T, RAM[0x40]=0x20080005 -> if_gnt and mem_addr=0x40 at T, busy at T+1, if_rvalid=1 with if_rdata=0x20080005 at T+2.
3. Contention: if_req and dm_req (read, 0x100) together at T -> dm_gnt at T, dm_rvalid at T+2, if_gnt at T+2, if_rvalid at T+4.
4. Write: dm_req, dm_we=1, addr=0x104, wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle with those values, no dm_rvalid, pending if_req granted next cycle; RAM readback gives 0xDEADBEEF.
5. Starvation, LAT=1, STARVE_MAX=4: dm_req and if_req held continuously -> dm_gnt on 4 consecutive cycles, if_gnt on the 5th, then DM resumes.
6. Reset mid-read: dm read granted at T, rst=0 at T+1 for one cycle -> no dm_rvalid at T+2, busy=0, and a new request is granted after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port RAM between the instruction-fetch requester (IF) and
// the load/store requester (DM). DM has fixed priority, but a starvation
// counter forces an IF grant after STARVE_MAX consecutive DM grants while IF
// is waiting. Reads hold the port for LAT cycles; the read data is handed back
// to whichever requester owned the read, with a one-cycle valid pulse.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   i_if_req, i_if_addr        fetch read request / address (held until o_if_gnt)
//   o_if_gnt                   fetch request accepted this cycle
//   o_if_rvalid, o_if_rdata    fetch read data valid pulse / data
//   i_dm_req, i_dm_we          data request / 1 = write (held until o_dm_gnt)
//   i_dm_addr, i_dm_wdata      data address / write data
//   o_dm_gnt                   data request accepted this cycle
//   o_dm_rvalid, o_dm_rdata    data read valid pulse / data (reads only)
//   o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata   RAM port
//   o_busy                     read outstanding, no grant possible this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_dm_req,
    input  logic          i_dm_we,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic          o_dm_gnt,
    output logic          o_dm_rvalid,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [2:0] CNT_INIT   = 3'(LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_count;
    logic [2:0]    w_count_next;
    logic          r_owner_dm;
    logic          w_owner_next;
    logic [3:0]    r_starve;
    logic [3:0]    w_starve_next;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    logic w_final;
    logic w_arb_ok;
    logic w_dm_win;
    logic w_if_win;
    logic w_if_rvalid;
    logic w_dm_rvalid;

    // Arbitration and next-state logic
    always_comb begin
        // The last WAIT cycle returns data and may also start the next access.
        w_final     = (r_state == ST_WAIT) && (r_count == 3'd0);
        // rst_n is included so no grant is ever presented while held in reset.
        w_arb_ok    = rst_n && ((r_state == ST_IDLE) || w_final);
        w_if_rvalid = w_final && !r_owner_dm;
        w_dm_rvalid = w_final && r_owner_dm;

        // DM loses only when IF is waiting and the starvation limit is reached.
        w_dm_win = w_arb_ok && i_dm_req && ((r_starve < STARVE_LIM) || !i_if_req);
        w_if_win = w_arb_ok && i_if_req && !w_dm_win;

        w_state_next = r_state;
        w_count_next = r_count;
        w_owner_next = r_owner_dm;

        if (r_state == ST_WAIT) begin
            if (r_count != 3'd0) begin
                w_count_next = r_count - 3'd1;
            end else begin
                w_state_next = ST_IDLE;
            end
        end

        // Writes finish in the grant cycle; only reads occupy the port.
        if (w_dm_win && !i_dm_we) begin
            w_state_next = ST_WAIT;
            w_count_next = CNT_INIT;
            w_owner_next = 1'b1;
        end else if (w_if_win) begin
            w_state_next = ST_WAIT;
            w_count_next = CNT_INIT;
            w_owner_next = 1'b0;
        end

        w_starve_next = r_starve;
        if (!i_if_req || w_if_win) begin
            w_starve_next = 4'd0;
        end else if (w_dm_win && (r_starve < STARVE_LIM)) begin
            w_starve_next = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 3'd0;
            r_owner_dm <= 1'b0;
            r_starve   <= 4'd0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_owner_dm <= w_owner_next;
            r_starve   <= w_starve_next;
            if (w_if_rvalid) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_dm_rvalid) begin
                r_dm_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_if_gnt    = w_if_win;
    assign o_dm_gnt    = w_dm_win;
    assign o_if_rvalid = w_if_rvalid;
    assign o_dm_rvalid = w_dm_rvalid;
    // Data is forwarded straight from the RAM in the valid cycle and held after.
    assign o_if_rdata  = w_if_rvalid ? i_mem_rdata : r_if_rdata;
    assign o_dm_rdata  = w_dm_rvalid ? i_mem_rdata : r_dm_rdata;
    assign o_mem_we    = w_dm_win && i_dm_we;
    assign o_mem_addr  = w_dm_win ? i_dm_addr : (w_if_win ? i_if_addr : '0);
    assign o_mem_wdata = w_dm_win ? i_dm_wdata : '0;
    assign o_busy      = (r_state == ST_WAIT) && (r_count != 3'd0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench. Instance u_dut (LAT=2) is driven from a per-cycle vector
// table; instance u_dut1 (LAT=1) runs the starvation sequence by hand.
// Each instance has its own RAM model with the matching read latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] D40   = 32'h2008_0005;
    localparam logic [31:0] D44   = 32'h2222_2222;
    localparam logic [31:0] D100  = 32'h1111_1111;
    localparam logic [31:0] D108  = 32'h5555_5555;
    localparam logic [31:0] DBEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] S200  = 32'hAAAA_0001;
    localparam logic [31:0] S240  = 32'hBBBB_0002;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance 0 (LAT=2) ----------------
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    logic [31:0] ram0 [0:1023];
    logic [31:0] pipe0_a, pipe0_b;
    always @(posedge clk) begin
        if (!rst_n) begin
            ram0[10'h040] <= D40;
            ram0[10'h044] <= D44;
            ram0[10'h100] <= D100;
            ram0[10'h108] <= D108;
        end else if (mem_we) begin
            ram0[mem_addr[9:0]] <= mem_wdata;
        end
        pipe0_a <= mem_addr;
        pipe0_b <= pipe0_a;
    end
    assign mem_rdata = ram0[pipe0_b[9:0]];

    // ---------------- instance 1 (LAT=1) ----------------
    logic        s_if_req = 1'b0, s_dm_req = 1'b0;
    logic        s_if_gnt, s_if_rvalid, s_dm_gnt, s_dm_rvalid, s_mem_we, s_busy;
    logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [31:0] s_if_addr = 32'h240, s_dm_addr = 32'h200, s_dm_wdata = '0;
    logic        s_dm_we = 1'b0;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(s_if_req), .i_if_addr(s_if_addr),
        .o_if_gnt(s_if_gnt), .o_if_rvalid(s_if_rvalid), .o_if_rdata(s_if_rdata),
        .i_dm_req(s_dm_req), .i_dm_we(s_dm_we), .i_dm_addr(s_dm_addr), .i_dm_wdata(s_dm_wdata),
        .o_dm_gnt(s_dm_gnt), .o_dm_rvalid(s_dm_rvalid), .o_dm_rdata(s_dm_rdata),
        .o_mem_we(s_mem_we), .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata),
        .i_mem_rdata(s_mem_rdata), .o_busy(s_busy)
    );

    logic [31:0] ram1 [0:1023];
    logic [31:0] pipe1_a;
    always @(posedge clk) begin
        if (!rst_n) begin
            ram1[10'h200] <= S200;
            ram1[10'h240] <= S240;
        end else if (s_mem_we) begin
            ram1[s_mem_addr[9:0]] <= s_mem_wdata;
        end
        pipe1_a <= s_mem_addr;
    end
    assign s_mem_rdata = ram1[pipe1_a[9:0]];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, ifr;
        logic [31:0] ifa;
        logic        dmr, dmw;
        logic [31:0] dma, dmd;
        logic        ig, dg, iv, dv, we, bsy;
        logic [31:0] ma, md, ird, drd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst ifr ifa      dmr dmw dma      dmd     ig dg iv dv we bsy  ma       md     ird   drd
        // reset held with both requests pending
        vecs.push_back(vec_t'{0, 1, 32'h40, 1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 32'h40, 1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 32'h0});
        // release: DM wins first, IF granted in DM's rvalid cycle
        vecs.push_back(vec_t'{1, 1, 32'h40, 1, 0, 32'h100, 32'h0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 1, 32'h40, 0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 1, 32'h40, 0, 0, 32'h0,   32'h0, 1, 0, 0, 1, 0, 0, 32'h40,  32'h0, 32'h0, D100});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, 32'h0, D100});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h0, D40,   D100});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, D40,   D100});
        // contention: DM read 0x108 and IF 0x44 together
        vecs.push_back(vec_t'{1, 1, 32'h44, 1, 0, 32'h108, 32'h0, 0, 1, 0, 0, 0, 0, 32'h108, 32'h0, D40,   D100});
        vecs.push_back(vec_t'{1, 1, 32'h44, 0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, D40,   D100});
        vecs.push_back(vec_t'{1, 1, 32'h44, 0, 0, 32'h0,   32'h0, 1, 0, 0, 1, 0, 0, 32'h44,  32'h0, D40,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, D40,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h0, D44,   D108});
        // write 0x104 with IF pending: one-cycle mem_we, IF granted next cycle
        vecs.push_back(vec_t'{1, 1, 32'h40, 1, 1, 32'h104, DBEEF, 0, 1, 0, 0, 1, 0, 32'h104, DBEEF, D44,   D108});
        vecs.push_back(vec_t'{1, 1, 32'h40, 0, 0, 32'h0,   32'h0, 1, 0, 0, 0, 0, 0, 32'h40,  32'h0, D44,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, D44,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h0, D40,   D108});
        // read back the written word
        vecs.push_back(vec_t'{1, 0, 32'h0,  1, 0, 32'h104, 32'h0, 0, 1, 0, 0, 0, 0, 32'h104, 32'h0, D40,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, D40,   D108});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 1, 0, 0, 32'h0,   32'h0, D40,   DBEEF});
        // reset in the middle of a DM read: no rvalid afterwards
        vecs.push_back(vec_t'{1, 0, 32'h0,  1, 0, 32'h100, 32'h0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h0, D40,   DBEEF});
        vecs.push_back(vec_t'{0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 1, 32'h40, 0, 0, 32'h0,   32'h0, 1, 0, 0, 0, 0, 0, 32'h40,  32'h0, 32'h0, 32'h0});
        // DM blocked while busy, granted in IF's rvalid cycle
        vecs.push_back(vec_t'{1, 0, 32'h0,  1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 0, 32'h0,  1, 0, 32'h100, 32'h0, 0, 1, 1, 0, 0, 0, 32'h100, 32'h0, D40,   32'h0});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0, D40,   32'h0});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 1, 0, 0, 32'h0,   32'h0, D40,   D100});
        vecs.push_back(vec_t'{1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0, D40,   D100});

        // Each row is one clock cycle: drive just after the rising edge,
        // compare on the falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n    = vecs[i].rst_n;
            if_req   = vecs[i].ifr;
            if_addr  = vecs[i].ifa;
            dm_req   = vecs[i].dmr;
            dm_we    = vecs[i].dmw;
            dm_addr  = vecs[i].dma;
            dm_wdata = vecs[i].dmd;
            @(negedge clk);
            chk($sformatf("row%0d if_gnt", i),    {31'b0, if_gnt},    {31'b0, vecs[i].ig});
            chk($sformatf("row%0d dm_gnt", i),    {31'b0, dm_gnt},    {31'b0, vecs[i].dg});
            chk($sformatf("row%0d if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].iv});
            chk($sformatf("row%0d dm_rvalid", i), {31'b0, dm_rvalid}, {31'b0, vecs[i].dv});
            chk($sformatf("row%0d mem_we", i),    {31'b0, mem_we},    {31'b0, vecs[i].we});
            chk($sformatf("row%0d busy", i),      {31'b0, busy},      {31'b0, vecs[i].bsy});
            chk($sformatf("row%0d mem_addr", i),  mem_addr,  vecs[i].ma);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].md);
            chk($sformatf("row%0d if_rdata", i),  if_rdata,  vecs[i].ird);
            chk($sformatf("row%0d dm_rdata", i),  dm_rdata,  vecs[i].drd);
            $display("row %0d: rst_n=%0b gnt(if/dm)=%0b/%0b rvalid(if/dm)=%0b/%0b we=%0b busy=%0b addr=%h",
                     i, rst_n, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we, busy, mem_addr);
        end

        // Starvation on the LAT=1 instance: both requesters held continuously.
        // Expected grant pattern DM x4, IF x1, repeating; rvalid follows a cycle later.
        @(posedge clk);
        #1;
        s_if_req = 1'b1;
        s_dm_req = 1'b1;
        for (int k = 0; k < 11; k++) begin
            logic exp_ig, exp_dg, exp_iv, exp_dv;
            exp_ig = (k < 10) && ((k % 5) == 4);
            exp_dg = (k < 10) && ((k % 5) != 4);
            exp_iv = (k >= 1) && (((k - 1) % 5) == 4);
            exp_dv = (k >= 1) && (((k - 1) % 5) != 4);
            @(negedge clk);
            chk($sformatf("starve%0d if_gnt", k),    {31'b0, s_if_gnt},    {31'b0, exp_ig});
            chk($sformatf("starve%0d dm_gnt", k),    {31'b0, s_dm_gnt},    {31'b0, exp_dg});
            chk($sformatf("starve%0d if_rvalid", k), {31'b0, s_if_rvalid}, {31'b0, exp_iv});
            chk($sformatf("starve%0d dm_rvalid", k), {31'b0, s_dm_rvalid}, {31'b0, exp_dv});
            chk($sformatf("starve%0d busy", k),      {31'b0, s_busy},      32'h0);
            if (k < 10) begin
                chk($sformatf("starve%0d mem_addr", k), s_mem_addr, exp_ig ? 32'h240 : 32'h200);
            end
            if (exp_iv) begin
                chk($sformatf("starve%0d if_rdata", k), s_if_rdata, S240);
            end
            if (exp_dv) begin
                chk($sformatf("starve%0d dm_rdata", k), s_dm_rdata, S200);
            end
            $display("starve cycle %0d: gnt(if/dm)=%0b/%0b rvalid(if/dm)=%0b/%0b addr=%h",
                     k, s_if_gnt, s_dm_gnt, s_if_rvalid, s_dm_rvalid, s_mem_addr);
            @(posedge clk);
            #1;
            if (k == 9) begin
                s_if_req = 1'b0;
                s_dm_req = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
